// File: rtl/store_unit.sv
// store_unit -- store path of the rv32i multicycle datapath.
// Executes SB/SH/SW against a word-wide data memory that has no byte enables.
// SW is a single write; SB/SH read the word, replace the addressed lane and
// write it back. Misaligned or illegal requests are rejected without a write.
//
// Ports
//   clk_i, rst_i     clock, synchronous active-high reset
//   req_valid_i      store request present
//   req_ready_o      unit idle; request accepted this cycle if req_valid_i=1
//   req_addr_i       byte address
//   req_wdata_i      store data
//   req_funct3_i     000 SB, 001 SH, 010 SW; other codes illegal
//   done_o           one-cycle pulse: store committed or rejected
//   err_o            valid with done_o: request rejected, no write made
//   mem_addr_o       word index of the latched address
//   mem_re_o         read strobe; mem_rdata_i valid the following cycle
//   mem_rdata_i      read data from memory
//   mem_we_o         write strobe
//   mem_wdata_o      write data
module store_unit #(
  parameter int XLEN    = 32,
  parameter int WADDR_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [XLEN-1:0]    req_addr_i,
  input  logic [XLEN-1:0]    req_wdata_i,
  input  logic [2:0]         req_funct3_i,
  output logic               done_o,
  output logic               err_o,
  output logic [WADDR_W-1:0] mem_addr_o,
  output logic               mem_re_o,
  input  logic [XLEN-1:0]    mem_rdata_i,
  output logic               mem_we_o,
  output logic [XLEN-1:0]    mem_wdata_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_MERGE, S_WRITE, S_DONE, S_ERR
  } state_t;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  state_t              state_q;
  logic [WADDR_W+1:0]  addr_q;
  logic [XLEN-1:0]     wdata_q;
  logic [2:0]          funct3_q;
  logic [XLEN-1:0]     mem_wdata_q;
  logic                ready_q, re_q, we_q, done_q, err_q;

  logic [XLEN-1:0]     merged_d;
  logic                bad_req;

  // Address bits above the word index are dropped: accesses wrap modulo memory size.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr_i[XLEN-1:WADDR_W+2];

  assign bad_req = (req_funct3_i > F3_SW)
                || (req_funct3_i == F3_SH && req_addr_i[0])
                || (req_funct3_i == F3_SW && req_addr_i[1:0] != 2'b00);

  // Lane replacement on the word read back from memory; untouched lanes preserved.
  always_comb begin
    merged_d = mem_rdata_i;
    if (funct3_q == F3_SB)
      merged_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else
      merged_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      funct3_q    <= '0;
      mem_wdata_q <= '0;
      ready_q     <= 1'b1;
      re_q        <= 1'b0;
      we_q        <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            addr_q   <= req_addr_i[WADDR_W+1:0];
            wdata_q  <= req_wdata_i;
            funct3_q <= req_funct3_i;
            ready_q  <= 1'b0;
            if (bad_req) begin
              state_q <= S_ERR;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (req_funct3_i == F3_SW) begin
              state_q     <= S_WRITE;
              mem_wdata_q <= req_wdata_i;
              we_q        <= 1'b1;
            end else begin
              state_q <= S_READ;
              re_q    <= 1'b1;
            end
          end
        end
        S_READ: begin
          state_q <= S_MERGE;
          re_q    <= 1'b0;
        end
        S_MERGE: begin
          state_q     <= S_WRITE;
          mem_wdata_q <= merged_d;
          we_q        <= 1'b1;
        end
        S_WRITE: begin
          state_q <= S_DONE;
          we_q    <= 1'b0;
          done_q  <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        S_ERR: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          re_q    <= 1'b0;
          we_q    <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign mem_re_o    = re_q;
  // Gated so that no write can land in any cycle with reset asserted.
  assign mem_we_o    = we_q & ~rst_i;
  assign mem_addr_o  = addr_q[WADDR_W+1:2];
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_store_unit.sv
module tb_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        done;
  logic        err;
  logic [7:0]  mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata;

  always #5 clk = ~clk;

  store_unit #(.XLEN(32), .WADDR_W(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_funct3_i (req_funct3),
    .done_o       (done),
    .err_o        (err),
    .mem_addr_o   (mem_addr),
    .mem_re_o     (mem_re),
    .mem_rdata_i  (mem_rdata),
    .mem_we_o     (mem_we),
    .mem_wdata_o  (mem_wdata)
  );

  // Word-wide memory with registered read and a bench-side preload port.
  logic [31:0] mem [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  int re_cnt = 0, we_cnt = 0, done_cnt = 0, overlap_cnt = 0;
  always @(negedge clk) begin
    if (mem_re) re_cnt++;
    if (mem_we) we_cnt++;
    if (done) done_cnt++;
    if (mem_re && mem_we) overlap_cnt++;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Issues one request; lat = edges from accept until done seen (-1 on timeout).
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                          output int lat, output logic e);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!req_ready) chk("ready_wait", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_addr = a; req_wdata = d; req_funct3 = f3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr = 32'hFFFF_FFFF; req_wdata = ~d; req_funct3 = 3'b111;
    lat = 1;
    while (!done && lat < 10) begin @(posedge clk); #1; lat++; end
    if (!done) lat = -1;
    e = err;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [7:0]  idx;
    logic [31:0] init;
    logic [31:0] exp_word;
    int          exp_lat;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int lat, r0, w0, d0;
    logic e;

    vecs[0]  = '{32'h0000_0100, 32'hDEAD_BEEF, 3'b010, 8'h40, 32'h0000_0000, 32'hDEAD_BEEF, 2, 1'b0};
    vecs[1]  = '{32'h0000_0101, 32'h0000_0012, 3'b000, 8'h40, 32'hFFFF_FFFF, 32'hFFFF_12FF, 4, 1'b0};
    vecs[2]  = '{32'h0000_0102, 32'h0000_ABCD, 3'b001, 8'h40, 32'h1122_3344, 32'hABCD_3344, 4, 1'b0};
    vecs[3]  = '{32'h0000_0101, 32'h0000_5555, 3'b001, 8'h40, 32'h1122_3344, 32'h1122_3344, 1, 1'b1};
    vecs[4]  = '{32'h0000_0102, 32'h9999_9999, 3'b010, 8'h40, 32'h1122_3344, 32'h1122_3344, 1, 1'b1};
    vecs[5]  = '{32'h0000_0100, 32'h7777_7777, 3'b011, 8'h40, 32'h1122_3344, 32'h1122_3344, 1, 1'b1};
    vecs[6]  = '{32'h0000_0103, 32'h0000_00AB, 3'b000, 8'h40, 32'h0000_0000, 32'hAB00_0000, 4, 1'b0};
    vecs[7]  = '{32'h0000_0100, 32'hFFFF_FF5A, 3'b000, 8'h40, 32'h1234_5678, 32'h1234_565A, 4, 1'b0};
    vecs[8]  = '{32'h0000_0100, 32'h1234_BEEF, 3'b001, 8'h40, 32'hAAAA_AAAA, 32'hAAAA_BEEF, 4, 1'b0};
    vecs[9]  = '{32'h0000_0504, 32'hCAFE_F00D, 3'b010, 8'h41, 32'h0000_0000, 32'hCAFE_F00D, 2, 1'b0};
    vecs[10] = '{32'h0000_0108, 32'h0000_0001, 3'b111, 8'h42, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 1, 1'b1};
    vecs[11] = '{32'h0000_0FFA, 32'h0000_0077, 3'b000, 8'hFE, 32'h0000_0000, 32'h0077_0000, 4, 1'b0};

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_err",   {31'd0, err}, 32'd0);
    chk("rst_re",    {31'd0, mem_re}, 32'd0);
    chk("rst_we",    {31'd0, mem_we}, 32'd0);
    chk("rst_addr",  {24'd0, mem_addr}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      preload(vecs[i].idx, vecs[i].init);
      r0 = re_cnt; w0 = we_cnt; d0 = done_cnt;
      do_store(vecs[i].addr, vecs[i].wdata, vecs[i].f3, lat, e);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
      chk($sformatf("v%0d_word", i), mem[vecs[i].idx], vecs[i].exp_word);
      chk($sformatf("v%0d_re_cycles", i), re_cnt - r0,
          (vecs[i].exp_err || vecs[i].f3 == 3'b010) ? 32'd0 : 32'd1);
      chk($sformatf("v%0d_we_cycles", i), we_cnt - w0, vecs[i].exp_err ? 32'd0 : 32'd1);
      chk($sformatf("v%0d_done_pulses", i), done_cnt - d0, 32'd1);
    end

    // Reset during MERGE abandons the SB.
    preload(8'h40, 32'hA5A5_A5A5);
    w0 = we_cnt; d0 = done_cnt;
    req_valid = 1'b1; req_addr = 32'h100; req_wdata = 32'h12; req_funct3 = 3'b000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mrst_we_cycles", we_cnt - w0, 32'd0);
    chk("mrst_done_pulses", done_cnt - d0, 32'd0);
    chk("mrst_ready", {31'd0, req_ready}, 32'd1);
    chk("mrst_word", mem[8'h40], 32'hA5A5_A5A5);
    do_store(32'h100, 32'h5, 3'b010, lat, e);
    chk("mrst_sw_latency", lat, 32'd2);
    chk("mrst_sw_word", mem[8'h40], 32'h5);

    // req_valid held high across two SW requests.
    preload(8'h80, 32'h0);
    preload(8'h81, 32'h0);
    w0 = we_cnt; d0 = done_cnt;
    req_valid = 1'b1; req_addr = 32'h200; req_wdata = 32'h1; req_funct3 = 3'b010;
    @(posedge clk); #1;
    req_addr = 32'h204; req_wdata = 32'h2;
    begin
      int n;
      n = 0;
      while (!req_ready && n < 10) begin @(posedge clk); #1; n++; end
      chk("b2b_ready_wait", n, 32'd2);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_word0", mem[8'h80], 32'h1);
    chk("b2b_word1", mem[8'h81], 32'h2);
    chk("b2b_done_pulses", done_cnt - d0, 32'd2);
    chk("b2b_we_cycles", we_cnt - w0, 32'd2);
    chk("b2b_ready_end", {31'd0, req_ready}, 32'd1);

    chk("re_we_overlap", overlap_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
